// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and the baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // FSM state codes, kept as plain constants for legacy tool compatibility
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Clock cycles per bit; integer division, caller guarantees the result is >= 4
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte request/response handshake between the time formatter and the UART transmitter.
interface uart_byte_tx_if;
  import uart_pkg::*;

  logic                 uart_tx_en;
  logic [DATA_BITS-1:0] uart_tx_data;
  logic                 uart_tx_done;
  logic                 uart_tx_busy;
  logic                 uart_tx_overrun;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    input  uart_tx_done,
    input  uart_tx_busy,
    input  uart_tx_overrun
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    output uart_tx_done,
    output uart_tx_busy,
    output uart_tx_overrun
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled, held at 0 while cleared.
// bit_tick_c marks the last cycle of a bit, pre_tick_c the cycle before it.
module uart_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, then wrap at the end of the bit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_c = enable & ~clear & (cnt_q == CNT_LAST);
  assign pre_tick_c = enable & ~clear & (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N/8O/8E with 1 or 2 stop bits, LSB first,
// with a one-deep holding register so a request during a frame is kept.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  bus,
  output logic           uart_txd
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                 load;
  logic [DATA_BITS-1:0] load_byte;
  logic                 bit_tick_c;
  logic                 pre_tick_c;

  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == ST_IDLE),
    .enable     (state_q != ST_IDLE),
    .bit_tick_c (bit_tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // Frame sequencing, request acceptance and registered output generation
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;
    par_d        = par_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    txd_d        = txd_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    load         = 1'b0;
    load_byte    = hold_q;

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (hold_valid_q) begin
          load         = 1'b1;
          hold_valid_d = 1'b0;
        end else if (bus.uart_tx_en) begin
          load      = 1'b1;
          load_byte = bus.uart_tx_data;
        end
      end
      ST_START: begin
        if (bit_tick_c) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_tick_c) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick_c) begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        // done is registered, so raise it one cycle before the final stop bit ends
        if (pre_tick_c && (stop_cnt_q == STOP_LAST)) begin
          done_d = 1'b1;
        end
        if (bit_tick_c) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (hold_valid_q) begin
            load         = 1'b1;
            hold_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A request that did not go straight to the shifter lands in the holding register if free
    if (bus.uart_tx_en && !hold_valid_q && (state_q != ST_IDLE)) begin
      hold_d       = bus.uart_tx_data;
      hold_valid_d = 1'b1;
    end
    if (bus.uart_tx_en && hold_valid_q) begin
      overrun_d = 1'b1;
    end

    if (load) begin
      state_d   = ST_START;
      txd_d     = 1'b0;
      shift_d   = load_byte;
      bit_idx_d = 3'd0;
      par_d     = (PARITY == PARITY_ODD) ? ~^load_byte : ^load_byte;
    end

    busy_d = (state_d != ST_IDLE) | hold_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      par_q        <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      par_q        <= par_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign uart_txd            = txd_q;
  assign bus.uart_tx_done    = done_q;
  assign bus.uart_tx_busy    = busy_q;
  assign bus.uart_tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three configurations (8N1, 8E1, 8O2) driven with the same
// requests, each compared every cycle against a frame-timeline reference model.
module tb_uart_byte_tx;
  import uart_pkg::*;

  localparam int ND  = 3;
  localparam int DIV = 10;
  localparam int PAR_CFG [ND] = '{0, 2, 1};
  localparam int STP_CFG [ND] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] data = 8'h00;

  always #5 clk = ~clk;

  uart_byte_tx_if bus0 ();
  uart_byte_tx_if bus1 ();
  uart_byte_tx_if bus2 ();

  logic [ND-1:0] txd_w, done_w, busy_w, ovr_w;

  assign bus0.uart_tx_en = en;  assign bus0.uart_tx_data = data;
  assign bus1.uart_tx_en = en;  assign bus1.uart_tx_data = data;
  assign bus2.uart_tx_en = en;  assign bus2.uart_tx_data = data;
  assign done_w = {bus2.uart_tx_done,    bus1.uart_tx_done,    bus0.uart_tx_done};
  assign busy_w = {bus2.uart_tx_busy,    bus1.uart_tx_busy,    bus0.uart_tx_busy};
  assign ovr_w  = {bus2.uart_tx_overrun, bus1.uart_tx_overrun, bus0.uart_tx_overrun};

  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0), .uart_txd(txd_w[0]));
  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1), .uart_txd(txd_w[1]));
  uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2), .uart_txd(txd_w[2]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model: frames as (start cycle, byte) on a timeline
  bit         m_act [ND];
  int         m_start [ND];
  int         m_len [ND];
  logic [7:0] m_byte [ND];
  bit         m_hv [ND];
  logic [7:0] m_hb [ND];
  bit         m_ovr [ND];

  function automatic logic frame_bit(input logic [7:0] b, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par != 0) return (par == 1) ? ~^b : ^b;
    return 1'b1;
  endfunction

  function automatic void start_frame(input int i, input logic [7:0] b, input int c);
    m_act[i]   = 1'b1;
    m_start[i] = c;
    m_byte[i]  = b;
    m_len[i]   = (9 + ((PAR_CFG[i] != 0) ? 1 : 0) + STP_CFG[i]) * DIV;
  endfunction

  // Advance one clock: inputs seen in cycle cyc decide what happens from cycle cyc+1
  function automatic void model_step(input int i);
    int p, c;
    bit hv0, idle0, done_prev;
    p = cyc;
    c = cyc + 1;
    if (rst) begin
      m_act[i] = 1'b0; m_hv[i] = 1'b0; m_ovr[i] = 1'b0;
      return;
    end
    hv0       = m_hv[i];
    idle0     = !m_act[i];
    done_prev = m_act[i] && (p == m_start[i] + m_len[i] - 1);
    m_ovr[i]  = en && hv0;
    if (done_prev) begin
      if (hv0) begin start_frame(i, m_hb[i], c); m_hv[i] = 1'b0; end
      else m_act[i] = 1'b0;
    end else if (idle0 && hv0) begin
      start_frame(i, m_hb[i], c);
      m_hv[i] = 1'b0;
    end
    if (en && !hv0) begin
      if (idle0) start_frame(i, data, c);
      else begin m_hv[i] = 1'b1; m_hb[i] = data; end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) model_step(i);
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every output of every configuration
  bit chk_on = 1'b0;
  int done_cnt [ND];
  int ovr_cnt [ND];
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < ND; i++) begin
        logic e_txd, e_done;
        e_txd  = m_act[i] ? frame_bit(m_byte[i], PAR_CFG[i], (cyc - m_start[i]) / DIV) : 1'b1;
        e_done = m_act[i] && (cyc == m_start[i] + m_len[i] - 1);
        check_eq($sformatf("txd%0d", i),  32'(txd_w[i]),  32'(e_txd));
        check_eq($sformatf("done%0d", i), 32'(done_w[i]), 32'(e_done));
        check_eq($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_act[i] || m_hv[i]));
        check_eq($sformatf("ovr%0d", i),  32'(ovr_w[i]),  32'(m_ovr[i]));
        if (done_w[i]) done_cnt[i]++;
        if (ovr_w[i])  ovr_cnt[i]++;
      end
    end
  end

  // ---------------- line decoder for the 8N1 instance
  bit         dec_on = 1'b0;
  logic [7:0] dec_b;
  logic [7:0] dec_q [$];
  initial begin
    forever begin
      @(negedge clk);
      if (dec_on && txd_w[0] == 1'b0) begin
        repeat (5) @(negedge clk);
        check_eq("dec_start", 32'(txd_w[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (10) @(negedge clk);
          dec_b[k] = txd_w[0];
        end
        repeat (10) @(negedge clk);
        check_eq("dec_stop", 32'(txd_w[0]), 32'd1);
        dec_q.push_back(dec_b);
      end
    end
  end

  // ---------------- stimulus helpers (all driving/sampling at #1 after posedge)
  task automatic go(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [7:0] b, output int t);
    t = cyc; en = 1'b1; data = b;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && busy_w != '0) begin @(posedge clk); #1; n++; end
    check_eq("idle_timeout", 32'(n < 2000), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  int         t0, tx, n, d0, o0;
  logic [7:0] b32;
  string      msg;

  initial begin
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("rst_txd",  32'(txd_w[0]),  32'd1);
    check_eq("rst_busy", 32'(busy_w[0]), 32'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // 1: 8'h32 on 8N1
    b32 = 8'h32;
    pulse(b32, t0);
    check_eq("t1_start", 32'(txd_w[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      go(t0 + 15 + 10 * k);
      check_eq($sformatf("t1_bit%0d", k), 32'(txd_w[0]), 32'(b32[k]));
    end
    go(t0 + 95);  check_eq("t1_stop", 32'(txd_w[0]), 32'd1);
    go(t0 + 99);  check_eq("t1_done_early", 32'(done_w[0]), 32'd0);
    go(t0 + 100); check_eq("t1_done", 32'(done_w[0]), 32'd1);
    check_eq("t1_busy_hi", 32'(busy_w[0]), 32'd1);
    go(t0 + 101); check_eq("t1_done_off", 32'(done_w[0]), 32'd0);
    check_eq("t1_busy_lo", 32'(busy_w[0]), 32'd0);
    wait_idle();

    // 2: parity bit on 8'h3A, even then odd
    pulse(8'h3A, t0);
    go(t0 + 95);  check_eq("t2_even_par", 32'(txd_w[1]), 32'd0);
    check_eq("t2_odd_par", 32'(txd_w[2]), 32'd1);
    go(t0 + 110); check_eq("t2_even_done", 32'(done_w[1]), 32'd1);
    go(t0 + 120); check_eq("t2_odd2_done", 32'(done_w[2]), 32'd1);
    wait_idle();

    // 3: second byte held, back-to-back frames
    d0 = done_cnt[0];
    pulse(8'h41, t0);
    go(t0 + 30); pulse(8'h42, tx);
    go(t0 + 100); check_eq("t3_done1", 32'(done_w[0]), 32'd1);
    go(t0 + 101); check_eq("t3_start2", 32'(txd_w[0]), 32'd0);
    go(t0 + 200); check_eq("t3_done2", 32'(done_w[0]), 32'd1);
    wait_idle();
    check_eq("t3_done_count", 32'(done_cnt[0] - d0), 32'd2);

    // 4: third request dropped
    pulse(8'h11, t0);
    go(t0 + 5); pulse(8'h22, tx);
    go(t0 + 7); pulse(8'h33, tx);
    go(t0 + 8); check_eq("t4_ovr", 32'(ovr_w[0]), 32'd1);
    go(t0 + 9); check_eq("t4_ovr_off", 32'(ovr_w[0]), 32'd0);
    wait_idle();

    // 5: request in the done cycle -> one idle cycle
    pulse(8'h55, t0);
    go(t0 + 100); pulse(8'h0A, tx);
    check_eq("t5_idle", 32'(txd_w[0]), 32'd1);
    go(t0 + 102); check_eq("t5_start", 32'(txd_w[0]), 32'd0);
    wait_idle();

    // 6: reset mid-frame, then a clean frame
    d0 = done_cnt[0];
    pulse(8'h6C, t0);
    go(t0 + 45); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_eq("t6_txd", 32'(txd_w[0]), 32'd1);
    check_eq("t6_busy", 32'(busy_w), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    pulse(8'h93, t0);
    wait_idle();
    check_eq("t6_done_count", 32'(done_cnt[0] - d0), 32'd1);

    // 7: formatter chain, paced by done
    msg = "2022-05-27 12:00:00\n";
    d0 = done_cnt[0]; o0 = ovr_cnt[0];
    dec_q.delete();
    dec_on = 1'b1;
    for (int i = 0; i < msg.len(); i++) begin
      pulse(msg[i], tx);
      n = 0;
      while (!done_w[0] && n < 300) begin @(posedge clk); #1; n++; end
      check_eq("t7_pace", 32'(n < 300), 32'd1);
    end
    wait_idle();
    repeat (20) begin @(posedge clk); #1; end
    dec_on = 1'b0;
    check_eq("t7_rx_count", 32'(dec_q.size()), 32'(msg.len()));
    for (int i = 0; i < msg.len() && i < dec_q.size(); i++)
      check_eq($sformatf("t7_rx%0d", i), 32'(dec_q[i]), 32'(msg[i]));
    check_eq("t7_done_count", 32'(done_cnt[0] - d0), 32'd20);
    check_eq("t7_ovr_count", 32'(ovr_cnt[0] - o0), 32'd0);

    // Random requests and occasional resets
    for (int k = 0; k < 5000; k++) begin
      en   = ($urandom_range(0, 29) == 0);
      data = 8'($urandom);
      rst  = ($urandom_range(0, 1999) == 0);
      @(posedge clk); #1;
    end
    en = 1'b0; rst = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
